// File: rtl/huff_frame_pack_pkg.sv
// Shared definitions for the compressed-frame output framer and the encoder table generator.
package huff_frame_pack_pkg;

  localparam int          TBL_ENTRIES   = 256;
  localparam logic [31:0] MAGIC_DEFAULT = 32'h4855_4600;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAGIC,
    ST_TBL,
    ST_PAYLOAD,
    ST_TRAILER
  } state_e;

  // Header word fetch: even address out, even data back, odd data back, word presented.
  typedef enum logic [1:0] {
    PH_RD_EVEN,
    PH_CAP_EVEN,
    PH_CAP_ODD,
    PH_PRESENT
  } tbl_phase_e;

endpackage

// File: rtl/frame_skid2.sv
// Two-entry 32-bit skid buffer; head entry drives the output, count tells the reader how full it is.
module frame_skid2 (
  input  logic        clk,
  input  logic        rstN,
  input  logic        in_valid_i,
  input  logic [31:0] in_data_i,
  input  logic        out_ready_i,
  output logic        out_valid_o,
  output logic [31:0] out_data_o,
  output logic [1:0]  count_o
);

  logic [31:0] slot0_q, slot0_d;
  logic [31:0] slot1_q, slot1_d;
  logic [1:0]  count_q, count_d;
  logic        pop;

  always_comb begin
    pop     = out_ready_i && (count_q != 2'd0);
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (in_valid_i) begin
          slot0_d = in_data_i;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (pop && in_valid_i) begin
          slot0_d = in_data_i;
        end else if (pop) begin
          count_d = 2'd0;
        end else if (in_valid_i) begin
          slot1_d = in_data_i;
          count_d = 2'd2;
        end
      end
      default: begin
        // A push while full and stalled cannot happen under the reader's credit rule.
        if (pop) begin
          slot0_d = slot1_q;
          if (in_valid_i) slot1_d = in_data_i;
          else            count_d = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= '0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = slot0_q;
  assign count_o     = count_q;

endmodule

// File: rtl/huff_frame_pack.sv
// Frame builder: magic word, packed VLC table header, FIFO payload, payload-count trailer.
//   state   | meaning
//   IDLE    | waiting for frame_start
//   MAGIC   | presenting magic/mode word
//   TBL     | fetching and presenting table entry pairs
//   PAYLOAD | draining the encoded FIFO through the skid buffer
//   TRAILER | presenting payload word count
module huff_frame_pack #(
  parameter int          TBL_ENTRIES = huff_frame_pack_pkg::TBL_ENTRIES,
  parameter logic [31:0] MAGIC       = huff_frame_pack_pkg::MAGIC_DEFAULT
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        frame_start,
  input  logic        mode_full,
  output logic        frame_done,
  output logic        busy,
  output logic [7:0]  tbl_addr,
  input  logic [15:0] tbl_data,
  input  logic        encode_done,
  output logic        rd_encode,
  input  logic [31:0] encode_data,
  input  logic        encode_valid,
  input  logic        encode_empty,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] payload_words
);

  import huff_frame_pack_pkg::*;

  state_e      state_q;
  tbl_phase_e  phase_q;
  logic        busy_q, frame_done_q, done_seen_q, inflight_q, hdr_valid_q;
  logic [7:0]  tbl_addr_q;
  logic [15:0] even_q;
  logic [31:0] hdr_data_q, payload_words_q;

  logic        in_payload, xfer, rd_en, drained;
  logic        skid_valid;
  logic [31:0] skid_data;
  logic [1:0]  skid_count;

  frame_skid2 u_skid (
    .clk         (clk),
    .rstN        (rstN),
    .in_valid_i  (encode_valid && inflight_q),
    .in_data_i   (encode_data),
    .out_ready_i (out_ready && in_payload),
    .out_valid_o (skid_valid),
    .out_data_o  (skid_data),
    .count_o     (skid_count)
  );

  assign in_payload = (state_q == ST_PAYLOAD);
  assign out_valid  = in_payload ? skid_valid : hdr_valid_q;
  assign out_data   = in_payload ? skid_data  : hdr_data_q;
  assign xfer       = out_valid && out_ready;

  // Credit covers both buffered words and the read whose data has not come back yet.
  assign rd_en   = in_payload && !encode_empty &&
                   ((skid_count + {1'b0, inflight_q}) < 2'd2);
  assign drained = done_seen_q && encode_empty && !inflight_q && (skid_count == 2'd0);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q         <= ST_IDLE;
      phase_q         <= PH_RD_EVEN;
      busy_q          <= 1'b0;
      frame_done_q    <= 1'b0;
      done_seen_q     <= 1'b0;
      inflight_q      <= 1'b0;
      hdr_valid_q     <= 1'b0;
      tbl_addr_q      <= '0;
      even_q          <= '0;
      hdr_data_q      <= '0;
      payload_words_q <= '0;
    end else begin
      frame_done_q <= 1'b0;
      inflight_q   <= rd_en;
      if (busy_q && encode_done) done_seen_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            state_q         <= ST_MAGIC;
            busy_q          <= 1'b1;
            done_seen_q     <= 1'b0;
            payload_words_q <= '0;
            hdr_data_q      <= {MAGIC[31:1], mode_full};
            hdr_valid_q     <= 1'b1;
          end
        end
        ST_MAGIC: begin
          if (xfer) begin
            state_q     <= ST_TBL;
            phase_q     <= PH_RD_EVEN;
            hdr_valid_q <= 1'b0;
            tbl_addr_q  <= '0;
          end
        end
        ST_TBL: begin
          case (phase_q)
            PH_RD_EVEN: begin
              tbl_addr_q <= tbl_addr_q + 8'd1;
              phase_q    <= PH_CAP_EVEN;
            end
            PH_CAP_EVEN: begin
              even_q  <= tbl_data;
              phase_q <= PH_CAP_ODD;
            end
            PH_CAP_ODD: begin
              hdr_data_q  <= {even_q, tbl_data};
              hdr_valid_q <= 1'b1;
              phase_q     <= PH_PRESENT;
            end
            default: begin
              if (xfer) begin
                hdr_valid_q <= 1'b0;
                if (tbl_addr_q == 8'(TBL_ENTRIES - 1)) begin
                  state_q <= ST_PAYLOAD;
                end else begin
                  tbl_addr_q <= tbl_addr_q + 8'd1;
                  phase_q    <= PH_RD_EVEN;
                end
              end
            end
          endcase
        end
        ST_PAYLOAD: begin
          if (xfer) payload_words_q <= payload_words_q + 32'd1;
          if (drained) begin
            state_q     <= ST_TRAILER;
            hdr_data_q  <= payload_words_q;
            hdr_valid_q <= 1'b1;
          end
        end
        ST_TRAILER: begin
          if (xfer) begin
            state_q      <= ST_IDLE;
            hdr_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_encode     = rd_en;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign tbl_addr      = tbl_addr_q;
  assign payload_words = payload_words_q;

endmodule

// File: tb/tb_huff_frame_pack.sv
// Directed bench for huff_frame_pack: table RAM and FIFO models, stream capture, per-scenario checks.
`timescale 1ns/1ps
module tb_huff_frame_pack;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        frame_start = 1'b0;
  logic        mode_full = 1'b0;
  logic        frame_done, busy, rd_encode, out_valid;
  logic [7:0]  tbl_addr;
  logic [15:0] tbl_data = '0;
  logic        encode_done = 1'b0;
  logic [31:0] encode_data = '0;
  logic        encode_valid = 1'b0;
  logic        encode_empty;
  logic [31:0] out_data, payload_words;
  logic        out_ready = 1'b1;

  int errors = 0;
  int checks = 0;
  logic bp_en = 1'b0;

  always #5 clk = ~clk;

  huff_frame_pack dut (
    .clk           (clk),
    .rstN          (rstN),
    .frame_start   (frame_start),
    .mode_full     (mode_full),
    .frame_done    (frame_done),
    .busy          (busy),
    .tbl_addr      (tbl_addr),
    .tbl_data      (tbl_data),
    .encode_done   (encode_done),
    .rd_encode     (rd_encode),
    .encode_data   (encode_data),
    .encode_valid  (encode_valid),
    .encode_empty  (encode_empty),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .payload_words (payload_words)
  );

  // Table RAM: entry i = 16'h8000 | i, one-cycle read latency.
  always @(posedge clk) tbl_data <= 16'h8000 | {8'h00, tbl_addr};

  logic [31:0] fifo_mem [0:4095];
  int   wr_ptr = 0, rd_ptr = 0, rd_cnt = 0;
  logic fifo_flush = 1'b0;
  assign encode_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    encode_valid <= 1'b0;
    if (fifo_flush) begin
      rd_ptr <= wr_ptr;
    end else if (rd_encode && (wr_ptr != rd_ptr)) begin
      encode_data  <= fifo_mem[rd_ptr % 4096];
      encode_valid <= 1'b1;
      rd_ptr       <= rd_ptr + 1;
      rd_cnt       <= rd_cnt + 1;
    end
  end

  logic [31:0] cap [0:8191];
  int   cap_n = 0, done_cnt = 0, fidx = 0, pay_cnt = 0, max_out = 0, stall_err = 0, done_long = 0;
  logic prev_stall = 1'b0, prev_done = 1'b0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rstN) begin
      fidx       <= 0;
      prev_stall <= 1'b0;
      prev_done  <= 1'b0;
    end else begin
      if (prev_stall && (!out_valid || (out_data !== prev_data))) stall_err <= stall_err + 1;
      prev_stall <= out_valid && !out_ready;
      prev_data  <= out_data;
      if (out_valid && out_ready) begin
        cap[cap_n % 8192] <= out_data;
        cap_n <= cap_n + 1;
        fidx  <= fidx + 1;
        if (fidx >= 129 && rd_cnt > pay_cnt) pay_cnt <= pay_cnt + 1;
      end
      if (frame_done) begin
        done_cnt <= done_cnt + 1;
        fidx     <= 0;
      end
      if (frame_done && prev_done) done_long <= done_long + 1;
      prev_done <= frame_done;
      if ((rd_cnt - pay_cnt) > max_out) max_out <= rd_cnt - pay_cnt;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = bp_en ? ($urandom_range(0, 2) == 0) : 1'b1;
    end
  end

  function automatic logic [31:0] exp_word(input int i, input logic mode,
                                           input logic [31:0] base, input int n);
    int k;
    if (i == 0) return 32'h4855_4600 | {31'd0, mode};
    if (i <= 128) begin
      k = i - 1;
      return {16'h8000 | 16'(2 * k), 16'h8000 | 16'(2 * k + 1)};
    end
    if (i <= 128 + n) return base + 32'(i - 129);
    return 32'(n);
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic fifo_push(input logic [31:0] w);
    fifo_mem[wr_ptr % 4096] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic start_frame(input logic mode);
    @(posedge clk); #1; frame_start = 1'b1; mode_full = mode;
    @(posedge clk); #1; frame_start = 1'b0;
  endtask

  task automatic pulse_done();
    @(posedge clk); #1; encode_done = 1'b1;
    @(posedge clk); #1; encode_done = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_done) begin ok = 1'b1; break; end
    end
    tick(1);
  endtask

  task automatic test_reset();
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (busy !== 1'b0 || frame_done !== 1'b0 || rd_encode !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: busy=%b done=%b rd=%b want 0", busy, frame_done, rd_encode); end
    checks++; if (tbl_addr !== 8'h0 || payload_words !== 32'h0) begin
      errors++; $display("FAIL reset_counts: addr=%h pw=%h want 0", tbl_addr, payload_words); end
    @(posedge clk); #1; rstN = 1'b1;
    tick(3);
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy=%b valid=%b want 0", busy, out_valid); end
  endtask

  task automatic test_basic_frame();
    int b, d0, bad; bit ok;
    for (int i = 0; i < 3; i++) fifo_push(32'hA0 + 32'(i));
    b = cap_n; d0 = done_cnt;
    start_frame(1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h4855_4601) begin
      errors++; $display("FAIL basic_first_latency: valid=%b data=%h want 1/48554601", out_valid, out_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
    pulse_done();
    wait_done(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: no frame_done within budget"); end
    checks++; if (cap_n - b != 133) begin errors++; $display("FAIL basic_len: got %0d want 133", cap_n - b); end
    checks++; if (cap[b] !== 32'h4855_4601) begin errors++; $display("FAIL basic_magic: got %h want 48554601", cap[b]); end
    checks++; if (cap[b+1] !== 32'h8000_8001 || cap[b+128] !== 32'h80FE_80FF) begin
      errors++; $display("FAIL basic_hdr_ends: got %h %h want 80008001 80fe80ff", cap[b+1], cap[b+128]); end
    checks++; if (cap[b+129] !== 32'hA0 || cap[b+131] !== 32'hA2) begin
      errors++; $display("FAIL basic_payload: got %h %h want a0 a2", cap[b+129], cap[b+131]); end
    checks++; if (cap[b+132] !== 32'h3) begin errors++; $display("FAIL basic_trailer: got %h want 3", cap[b+132]); end
    bad = 0;
    for (int i = 0; i < 133; i++) if (cap[b+i] !== exp_word(i, 1'b1, 32'hA0, 3)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL basic_stream: %0d wrong words want 0", bad); end
    checks++; if (done_cnt - d0 != 1 || done_long != 0) begin
      errors++; $display("FAIL basic_done_pulse: pulses=%0d long=%0d want 1/0", done_cnt - d0, done_long); end
    checks++; if (busy !== 1'b0 || payload_words !== 32'd3) begin
      errors++; $display("FAIL basic_end_state: busy=%b pw=%0d want 0/3", busy, payload_words); end
  endtask

  task automatic test_back_pressure();
    int b, s0, bad; bit ok;
    for (int i = 0; i < 3; i++) fifo_push(32'hA0 + 32'(i));
    b = cap_n; s0 = stall_err;
    bp_en = 1'b1;
    start_frame(1'b1);
    pulse_done();
    wait_done(8000, ok);
    bp_en = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: no frame_done within budget"); end
    checks++; if (cap_n - b != 133) begin errors++; $display("FAIL bp_len: got %0d want 133", cap_n - b); end
    bad = 0;
    for (int i = 0; i < 133; i++) if (cap[b+i] !== exp_word(i, 1'b1, 32'hA0, 3)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_stream: %0d wrong words want 0", bad); end
    checks++; if (stall_err != s0) begin errors++; $display("FAIL bp_stall_hold: %0d unstable stalls want 0", stall_err - s0); end
    checks++; if (max_out > 2) begin errors++; $display("FAIL bp_outstanding: max %0d want <=2", max_out); end
    checks++; if (payload_words !== 32'd3) begin errors++; $display("FAIL bp_count: got %0d want 3", payload_words); end
  endtask

  task automatic test_empty_payload();
    int b, bad; bit ok;
    b = cap_n;
    start_frame(1'b0);
    pulse_done();
    wait_done(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL empty_timeout: no frame_done within budget"); end
    checks++; if (cap_n - b != 130) begin errors++; $display("FAIL empty_len: got %0d want 130", cap_n - b); end
    checks++; if (cap[b] !== 32'h4855_4600) begin errors++; $display("FAIL empty_magic: got %h want 48554600", cap[b]); end
    checks++; if (cap[b+129] !== 32'h0) begin errors++; $display("FAIL empty_trailer: got %h want 0", cap[b+129]); end
    bad = 0;
    for (int i = 0; i < 130; i++) if (cap[b+i] !== exp_word(i, 1'b0, 32'h0, 0)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL empty_stream: %0d wrong words want 0", bad); end
  endtask

  task automatic test_late_done();
    int b, bad; bit ok;
    b = cap_n;
    start_frame(1'b1);
    fork
      begin
        for (int i = 0; i < 1000; i++) begin fifo_push(32'h1000_0000 + 32'(i)); tick(3); end
        tick(50);
        pulse_done();
      end
      wait_done(8000, ok);
    join
    checks++; if (!ok) begin errors++; $display("FAIL late_timeout: no frame_done within budget"); end
    checks++; if (cap_n - b != 1130) begin errors++; $display("FAIL late_len: got %0d want 1130", cap_n - b); end
    checks++; if (cap[b+1129] !== 32'h3E8) begin errors++; $display("FAIL late_trailer: got %h want 3e8", cap[b+1129]); end
    bad = 0;
    for (int i = 0; i < 1130; i++) if (cap[b+i] !== exp_word(i, 1'b1, 32'h1000_0000, 1000)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL late_stream: %0d wrong words want 0", bad); end
    checks++; if (payload_words !== 32'd1000) begin errors++; $display("FAIL late_count: got %0d want 1000", payload_words); end
    checks++; if (max_out > 2) begin errors++; $display("FAIL late_outstanding: max %0d want <=2", max_out); end
  endtask

  task automatic test_ignored_events();
    int b, d0, bad; bit ok, seen;
    fifo_push(32'hD0); fifo_push(32'hD1);
    b = cap_n; d0 = done_cnt;
    start_frame(1'b1);
    pulse_done();
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin @(negedge clk); if (cap_n - b >= 5) begin seen = 1'b1; break; end end
    checks++; if (!seen) begin errors++; $display("FAIL ign_reach_tbl: only %0d words out", cap_n - b); end
    start_frame(1'b0);
    wait_done(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ign_timeout: no frame_done within budget"); end
    bad = 0;
    for (int i = 0; i < 132; i++) if (cap[b+i] !== exp_word(i, 1'b1, 32'hD0, 2)) bad++;
    checks++; if (bad != 0 || cap_n - b != 132) begin
      errors++; $display("FAIL ign_stream: %0d wrong words, len %0d want 0/132", bad, cap_n - b); end
    tick(3);
    checks++; if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL ign_restart: pulses=%0d busy=%b want 1/0", done_cnt - d0, busy); end
    pulse_done();
    tick(3);
    fifo_push(32'hE0);
    b = cap_n; d0 = done_cnt;
    start_frame(1'b1);
    tick(700);
    checks++; if (cap_n - b != 130 || done_cnt != d0) begin
      errors++; $display("FAIL ign_wait_done: len=%0d pulses=%0d want 130/0", cap_n - b, done_cnt - d0); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy_wait: got %b want 1", busy); end
    pulse_done();
    wait_done(200, ok);
    checks++; if (!ok || cap_n - b != 131 || cap[b+130] !== 32'h1) begin
      errors++; $display("FAIL ign_fresh_done: ok=%b len=%0d trailer=%h want 1/131/1", ok, cap_n - b, cap[b+130]); end
  endtask

  task automatic test_reset_mid_payload();
    int b, bad; bit ok, found;
    for (int i = 0; i < 10; i++) fifo_push(32'hC0 + 32'(i));
    b = cap_n;
    start_frame(1'b0);
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if ((cap_n - b) >= 131 && rd_encode) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL rst_find_read: no payload read seen"); end
    @(posedge clk); #1;
    checks++; if (payload_words < 32'd1) begin errors++; $display("FAIL rst_pre_count: got %0d want >=1", payload_words); end
    rstN = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || rd_encode !== 1'b0) begin
      errors++; $display("FAIL rst_mid_data: valid=%b data=%h rd=%b want 0", out_valid, out_data, rd_encode); end
    checks++; if (busy !== 1'b0 || frame_done !== 1'b0 || tbl_addr !== 8'h0 || payload_words !== 32'h0) begin
      errors++; $display("FAIL rst_mid_ctrl: busy=%b done=%b addr=%h pw=%h want 0", busy, frame_done, tbl_addr, payload_words); end
    @(posedge clk); #1; rstN = 1'b1; fifo_flush = 1'b1;
    tick(1); fifo_flush = 1'b0;
    tick(2);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_no_trailer: valid=%b busy=%b want 0", out_valid, busy); end
    fifo_push(32'hB0); fifo_push(32'hB1);
    b = cap_n;
    start_frame(1'b1);
    checks++; if (payload_words !== 32'h0) begin errors++; $display("FAIL rst_count_restart: got %0d want 0", payload_words); end
    pulse_done();
    wait_done(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_next_timeout: no frame_done within budget"); end
    bad = 0;
    for (int i = 0; i < 132; i++) if (cap[b+i] !== exp_word(i, 1'b1, 32'hB0, 2)) bad++;
    checks++; if (bad != 0 || cap_n - b != 132) begin
      errors++; $display("FAIL rst_next_stream: %0d wrong words, len %0d want 0/132", bad, cap_n - b); end
    checks++; if (payload_words !== 32'd2) begin errors++; $display("FAIL rst_next_count: got %0d want 2", payload_words); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_pressure();
    test_empty_payload();
    test_late_done();
    test_ignored_events();
    test_reset_mid_payload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
